n64_vdemux_vinfo: RTL

- First stage of the picture processing path. Runs on the N64 video clock and sits directly downstream of the N64 video input pins.
- Demultiplexes the 7-bit time-multiplexed N64 video bus (sync nibble, R, G, B per pixel) into one parallel pixel word with a single-cycle valid strobe.
- Extracts per-field video info (lines per field, PAL/NTSC, 240p/480i) and passes it to the PPU and the controller status word.

---
 rtl/n64_vdemux_vinfo.sv | 115 +++++++++++
 1 files changed

// File: rtl/n64_vdemux_vinfo.sv
// N64 video input demultiplexer: splits the 4-phase VD bus (sync, R, G, B) into
// one parallel pixel word and derives per-field line count, PAL/NTSC and 480i info.
module n64_vdemux_vinfo #(
  parameter int                    color_width     = 7,
  parameter int                    LINE_CNT_W      = 10,
  parameter logic [LINE_CNT_W-1:0] PAL_LINE_THRESH = 10'd288
) (
  input  logic                   VCLK,
  input  logic                   nVRST,
  input  logic                   nVDSYNC,
  input  logic [color_width-1:0] VD_i,
  output logic                   vdata_valid_o,
  output logic [3:0]             vdata_sync_o,
  output logic [color_width-1:0] vdata_r_o,
  output logic [color_width-1:0] vdata_g_o,
  output logic [color_width-1:0] vdata_b_o,
  output logic                   phase_err_o,
  output logic [LINE_CNT_W-1:0]  line_cnt_o,
  output logic [LINE_CNT_W-1:0]  lines_per_field_o,
  output logic                   vmode_pal_o,
  output logic                   n64_480i_o
);

  typedef enum logic [1:0] {PH_IDLE, PH_R, PH_G, PH_B} phase_t;

  phase_t                 phase_q, phase_d;
  logic                   ld_sync, ld_r, ld_g, px_done, err_d;
  logic [3:0]             sync_sh;
  logic [color_width-1:0] r_sh, g_sh;
  logic [LINE_CNT_W-1:0]  prev_field_cnt, field_diff;
  logic                   hs_fall, vs_fall;

  always_ff @(posedge VCLK or negedge nVRST)
    if (!nVRST) phase_q <= PH_IDLE;
    else        phase_q <= phase_d;

  // A sync-low cycle always restarts the pixel; from R/G/B it also flags an error.
  always_comb begin
    phase_d = phase_q;
    ld_sync = 1'b0;
    ld_r    = 1'b0;
    ld_g    = 1'b0;
    px_done = 1'b0;
    err_d   = 1'b0;
    if (!nVDSYNC) begin
      ld_sync = 1'b1;
      err_d   = (phase_q != PH_IDLE);
      phase_d = PH_R;
    end else begin
      case (phase_q)
        PH_R:    begin ld_r = 1'b1; phase_d = PH_G; end
        PH_G:    begin ld_g = 1'b1; phase_d = PH_B; end
        PH_B:    begin px_done = 1'b1; phase_d = PH_IDLE; end
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge VCLK or negedge nVRST)
    if (!nVRST) begin
      sync_sh <= 4'hF;
      r_sh    <= '0;
      g_sh    <= '0;
    end else begin
      if (ld_sync) sync_sh <= VD_i[3:0];
      if (ld_r)    r_sh    <= VD_i;
      if (ld_g)    g_sh    <= VD_i;
    end

  // vdata_sync_o doubles as the previous-pixel sync for edge detection.
  assign hs_fall    = vdata_sync_o[1] & ~sync_sh[1];
  assign vs_fall    = vdata_sync_o[3] & ~sync_sh[3];
  assign field_diff = (line_cnt_o >= prev_field_cnt) ? (line_cnt_o - prev_field_cnt)
                                                     : (prev_field_cnt - line_cnt_o);

  always_ff @(posedge VCLK or negedge nVRST)
    if (!nVRST) begin
      vdata_valid_o <= 1'b0;
      phase_err_o   <= 1'b0;
      vdata_sync_o  <= 4'hF;
      vdata_r_o     <= '0;
      vdata_g_o     <= '0;
      vdata_b_o     <= '0;
    end else begin
      vdata_valid_o <= px_done;
      phase_err_o   <= err_d;
      if (px_done) begin
        vdata_sync_o <= sync_sh;
        vdata_r_o    <= r_sh;
        vdata_g_o    <= g_sh;
        vdata_b_o    <= VD_i;
      end
    end

  // Field info advances only with a completed pixel; vsync wins over a coincident hsync.
  always_ff @(posedge VCLK or negedge nVRST)
    if (!nVRST) begin
      line_cnt_o        <= '0;
      lines_per_field_o <= '0;
      prev_field_cnt    <= '0;
      vmode_pal_o       <= 1'b0;
      n64_480i_o        <= 1'b0;
    end else if (px_done) begin
      if (vs_fall) begin
        lines_per_field_o <= line_cnt_o;
        prev_field_cnt    <= line_cnt_o;
        vmode_pal_o       <= (line_cnt_o > PAL_LINE_THRESH);
        n64_480i_o        <= (field_diff == LINE_CNT_W'(1));
        line_cnt_o        <= '0;
      end else if (hs_fall && !(&line_cnt_o)) begin
        line_cnt_o <= line_cnt_o + 1'b1;
      end
    end

endmodule
